// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and defaults for the reset sequencer.
// Holds the FSM state encoding, default parameter values and width helpers.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_REL   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAULT = 3'd6
    } state_t;

    localparam int unsigned DEF_NUM_STAGE   = 4;
    localparam int unsigned DEF_HOLD_CYC    = 16;
    localparam int unsigned DEF_GAP_CYC     = 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 100_000_000;

    // Width of the shared counter: enough bits for the largest interval.
    function automatic int unsigned cnt_width(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Width of a stage index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser, WIDTH independent bits, async active-low reset.
// Ports: clk100m_slr0 clock, hw_arst_n_slr0 reset, d async input, q synchronised output.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk100m_slr0,
    input  logic             hw_arst_n_slr0,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk100m_slr0 or negedge hw_arst_n_slr0) begin
        if (!hw_arst_n_slr0) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: releases NUM_STAGE reset domains in order, waiting for each ack.
// Ports: clk_i, arst_n_i (async), sw_rst_n_i / stage_rdy_i (async inputs),
//        stage_rst_n_o, all_rdy_o, fault_o, fault_stage_o, busy_o (all registered).
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter  int unsigned NUM_STAGE   = DEF_NUM_STAGE,
    parameter  int unsigned HOLD_CYC    = DEF_HOLD_CYC,
    parameter  int unsigned GAP_CYC     = DEF_GAP_CYC,
    parameter  int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int unsigned KW          = idx_width(NUM_STAGE)
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 sw_rst_n_i,
    input  logic [NUM_STAGE-1:0] stage_rdy_i,
    output logic [NUM_STAGE-1:0] stage_rst_n_o,
    output logic                 all_rdy_o,
    output logic                 fault_o,
    output logic [KW-1:0]        fault_stage_o,
    output logic                 busy_o
);

    localparam int unsigned   CW        = cnt_width(HOLD_CYC, GAP_CYC, TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [KW-1:0] K_LAST    = KW'(NUM_STAGE - 1);

    logic                 sw_sync;
    logic [NUM_STAGE-1:0] rdy_sync;

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_STAGE-1:0] rst_n_d;
    logic                 all_rdy_d;
    logic                 fault_d;
    logic [KW-1:0]        fstage_d;
    logic                 busy_d;

    sync_2ff #(
        .WIDTH(1)
    ) u_sync_sw (
        .clk100m_slr0  (clk_i),
        .hw_arst_n_slr0(arst_n_i),
        .d             (sw_rst_n_i),
        .q             (sw_sync)
    );

    sync_2ff #(
        .WIDTH(NUM_STAGE)
    ) u_sync_rdy (
        .clk100m_slr0  (clk_i),
        .hw_arst_n_slr0(arst_n_i),
        .d             (stage_rdy_i),
        .q             (rdy_sync)
    );

    // One saturating counter serves HOLD, WAIT and GAP; every entry into
    // those states starts it from zero.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        rst_n_d  = stage_rst_n_o;
        fault_d  = fault_o;
        fstage_d = fault_stage_o;

        if (!sw_sync) begin
            // Software abort beats any ready or timeout seen this cycle.
            state_d = ST_IDLE;
            k_d     = '0;
            cnt_d   = '0;
            rst_n_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_HOLD;
                    k_d     = '0;
                    cnt_d   = '0;
                    rst_n_d = '0;
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d         = ST_REL;
                        rst_n_d[k_q]    = 1'b1;
                    end
                end
                ST_REL: begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
                ST_WAIT: begin
                    if (rdy_sync[k_q]) begin
                        cnt_d   = '0;
                        state_d = (k_q == K_LAST) ? ST_DONE : ST_GAP;
                    end else if (cnt_q == TMO_LAST) begin
                        state_d  = ST_FAULT;
                        fault_d  = 1'b1;
                        fstage_d = k_q;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d      = ST_REL;
                        k_d          = k_q + KW'(1);
                        rst_n_d[k_d] = 1'b1;
                    end
                end
                ST_DONE: begin
                    // Any domain losing ready forces a full re-sequence.
                    if (rdy_sync != '1) begin
                        state_d = ST_IDLE;
                        rst_n_d = '0;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                    k_d     = '0;
                    rst_n_d = '0;
                end
            endcase
        end

        all_rdy_d = (state_d == ST_DONE);
        busy_d    = state_d inside {ST_HOLD, ST_REL, ST_WAIT, ST_GAP};
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q       <= ST_IDLE;
            k_q           <= '0;
            cnt_q         <= '0;
            stage_rst_n_o <= '0;
            all_rdy_o     <= 1'b0;
            fault_o       <= 1'b0;
            fault_stage_o <= '0;
            busy_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            cnt_q         <= cnt_d;
            stage_rst_n_o <= rst_n_d;
            all_rdy_o     <= all_rdy_d;
            fault_o       <= fault_d;
            fault_stage_o <= fstage_d;
            busy_o        <= busy_d;
        end
    end

endmodule
